// File: rtl/brief_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : brief_window_gen
// Description : Builds a sliding 5x5 binary window from a 5-line pixel
//               column, tracks the pixel position, and flags windows whose
//               centre is at least 2 pixels from every frame edge.
//               Optional macro BRIEF_FRAME_CNT_EN adds a 16-bit frame counter
//               output (o_frame_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module brief_window_gen #(
  parameter int IMG_WIDTH  = 1080,
  parameter int IMG_HEIGHT = 720
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_sof,
  input  logic [4:0]  i_row_taps,
  output logic        o_valid,
  output logic [24:0] o_window,
  output logic [10:0] o_col,
  output logic [10:0] o_row,
  output logic        o_eof
`ifdef BRIEF_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame_cnt
`endif
);

  localparam logic [10:0] c_COL_LAST = 11'(IMG_WIDTH - 1);
  localparam logic [10:0] c_ROW_LAST = 11'(IMG_HEIGHT - 1);

  // Position expected for the next accepted pixel.
  logic [10:0] col_q, row_q;
  logic [10:0] col_d, row_d;
  logic [24:0] win_q, win_d;
  logic        valid_q, eof_q;
  logic [10:0] ocol_q, orow_q;

  // Position of the pixel being accepted this cycle (start-of-frame overrides).
  logic [10:0] pix_col, pix_row;
  logic        interior;
  logic        last_pix;

  // Pixel position, counter advance and window shift for the current strobe.
  always_comb begin
    pix_col  = i_sof ? 11'd0 : col_q;
    pix_row  = i_sof ? 11'd0 : row_q;
    interior = (pix_col >= 11'd4) && (pix_row >= 11'd4);
    last_pix = (pix_col == c_COL_LAST) && (pix_row == c_ROW_LAST);

    col_d = pix_col + 11'd1;
    row_d = pix_row;
    if (pix_col == c_COL_LAST) begin
      col_d = 11'd0;
      row_d = (pix_row == c_ROW_LAST) ? 11'd0 : pix_row + 11'd1;
    end

    // Each row moves one column left; the new column enters at dx=4 with
    // the oldest line (tap bit4) landing in the top row.
    win_d = '0;
    for (int dy = 0; dy < 5; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        win_d[5*dy+dx] = win_q[5*dy+dx+1];
      end
      win_d[5*dy+4] = i_row_taps[4-dy];
    end
  end

  // Counters, window and registered outputs; everything holds without a strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      ocol_q  <= '0;
      orow_q  <= '0;
    end else if (i_en) begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= interior;
      eof_q   <= interior && last_pix;
      // Coordinates only move when a window is actually emitted.
      if (interior) begin
        ocol_q <= pix_col - 11'd2;
        orow_q <= pix_row - 11'd2;
      end
    end else begin
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end
  end

  assign o_valid  = valid_q;
  assign o_eof    = eof_q;
  assign o_window = win_q;
  assign o_col    = ocol_q;
  assign o_row    = orow_q;

`ifdef BRIEF_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  // Completed-frame counter, bumped the cycle after each end-of-frame pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fcnt_q <= '0;
    end else if (eof_q) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign o_frame_cnt = fcnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_brief_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_brief_window_gen
// Description : Self-checking bench for brief_window_gen on an 8x6 image.
//               A frame-index model predicts every output each cycle; directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brief_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst, en, sof;
  logic [4:0]  taps;
  logic        o_valid, o_eof;
  logic [24:0] o_window;
  logic [10:0] o_col, o_row;
`ifdef BRIEF_FRAME_CNT_EN
  logic [15:0] o_frame_cnt;
`endif

  brief_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_sof      (sof),
    .i_row_taps (taps),
    .o_valid    (o_valid),
    .o_window   (o_window),
    .o_col      (o_col),
    .o_row      (o_row),
    .o_eof      (o_eof)
`ifdef BRIEF_FRAME_CNT_EN
    ,
    .o_frame_cnt(o_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pixel index within frame plus the last five accepted tap columns.
  int          n;
  logic [4:0]  hist [5];
  logic        ev, ee;
  logic [10:0] ecol, erow;
  logic [24:0] ewin;
  int          efc;

  // Per-scenario observations.
  int          vcount, ncalls, first_call, notfull, lowviol;
  int          first_col, first_row, last_col, last_row, last_eof;
  logic [24:0] wins [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    vcount = 0; ncalls = 0; first_call = -1; notfull = 0; lowviol = 0;
    first_col = -1; first_row = -1; last_col = -1; last_row = -1; last_eof = 0;
  endtask

  task automatic cyc(input logic r, input logic e, input logic s, input logic [4:0] t);
    int c, rw;
    @(negedge clk);
    rst = r; en = e; sof = s; taps = t;
    // Model update for this clock edge.
    if (r) begin
      n = 0;
      for (int i = 0; i < 5; i++) hist[i] = '0;
      ev = 0; ee = 0; ecol = '0; erow = '0; efc = 0;
    end else begin
      efc = (efc + (ee ? 1 : 0)) % 65536;
      if (e) begin
        if (s) n = 0;
        c  = n % W;
        rw = n / W;
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = t;
        ev = (c >= 4) && (rw >= 4);
        ee = ev && (c == W - 1) && (rw == H - 1);
        if (ev) begin
          ecol = 11'(c - 2);
          erow = 11'(rw - 2);
        end
        n = (n + 1) % (W * H);
      end else begin
        ev = 0; ee = 0;
      end
    end
    for (int dy = 0; dy < 5; dy++)
      for (int dx = 0; dx < 5; dx++)
        ewin[5*dy+dx] = hist[4-dx][4-dy];
    @(posedge clk);
    #1;
    chk("valid", {31'd0, o_valid}, {31'd0, ev});
    chk("eof", {31'd0, o_eof}, {31'd0, ee});
    chk("window", {7'd0, o_window}, {7'd0, ewin});
    if (ev || r) begin
      chk("col", {21'd0, o_col}, {21'd0, ecol});
      chk("row", {21'd0, o_row}, {21'd0, erow});
    end
`ifdef BRIEF_FRAME_CNT_EN
    chk("frame_cnt", {16'd0, o_frame_cnt}, efc);
`endif
    if (o_valid) begin
      if (vcount < 16) wins[vcount] = o_window;
      if (vcount == 0) begin
        first_col = int'(o_col); first_row = int'(o_row); first_call = ncalls;
      end
      vcount++;
      last_col = int'(o_col); last_row = int'(o_row); last_eof = int'(o_eof);
      if (o_window != 25'h1FFFFFF) notfull++;
      if (!e) lowviol++;
    end
    ncalls++;
  endtask

  task automatic frame_literals(input string tag);
    chk({tag, "_count"}, vcount, 8);
    chk({tag, "_first_col"}, first_col, 2);
    chk({tag, "_first_row"}, first_row, 2);
    chk({tag, "_last_col"}, last_col, 5);
    chk({tag, "_last_row"}, last_row, 3);
    chk({tag, "_last_eof"}, last_eof, 1);
    chk({tag, "_all_ones"}, notfull, 0);
  endtask

  initial begin
    rst = 1; en = 0; sof = 0; taps = '0;
    clear_obs();

    // Reset: all outputs zero, even with strobe and sof asserted.
    cyc(1, 0, 0, 5'h00);
    cyc(1, 1, 1, 5'h1F);
    chk("reset_valid", {31'd0, o_valid}, 0);
    chk("reset_window", {7'd0, o_window}, 0);

    // All-ones frame, continuous strobe.
    clear_obs();
    for (int p = 0; p < W * H; p++) cyc(0, 1, p == 0, 5'h1F);
    frame_literals("cont");

    // Single tap at pixel (4,4).
    cyc(1, 0, 0, 5'h00);
    clear_obs();
    for (int p = 0; p < W * H; p++) cyc(0, 1, p == 0, (p == 4 * W + 4) ? 5'h01 : 5'h00);
    chk("single_w0", {7'd0, wins[0]}, 32'h0100_0000);
    chk("single_w1", {7'd0, wins[1]}, 32'h0080_0000);
    chk("single_c1", last_col >= 0 ? 1 : 0, 1);

    // All-ones frame with the strobe low every other cycle.
    cyc(1, 0, 0, 5'h00);
    clear_obs();
    for (int p = 0; p < W * H; p++) begin
      cyc(0, 1, p == 0, 5'h1F);
      cyc(0, 0, 0, 5'h00);
    end
    frame_literals("gap");
    chk("gap_low_valid", lowviol, 0);

    // Start-of-frame mid frame at internal position (5,3).
    cyc(1, 0, 0, 5'h00);
    for (int p = 0; p < 3 * W + 5; p++) cyc(0, 1, p == 0, 5'h1F);
    clear_obs();
    for (int p = 0; p < 40; p++) cyc(0, 1, p == 0, 5'h1F);
    chk("sof_first_at", first_call, 4 * W + 4);
    chk("sof_first_col", first_col, 2);
    chk("sof_first_row", first_row, 2);

    // Reset pulse at pixel (6,5), then a full frame without sof.
    cyc(1, 0, 0, 5'h00);
    for (int p = 0; p < 5 * W + 6; p++) cyc(0, 1, p == 0, 5'h1F);
    cyc(1, 1, 0, 5'h1F);
    chk("rst_mid_valid", {31'd0, o_valid}, 0);
    chk("rst_mid_col", {21'd0, o_col}, 0);
    chk("rst_mid_window", {7'd0, o_window}, 0);
    clear_obs();
    for (int p = 0; p < W * H; p++) cyc(0, 1, 1'b0, 5'h1F);
    frame_literals("rst");

`ifdef BRIEF_FRAME_CNT_EN
    // Three full frames: counter steps 1, 2, 3 one cycle after each eof.
    cyc(1, 0, 0, 5'h00);
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < W * H; p++) cyc(0, 1, p == 0, 5'h1F);
    chk("fcnt_before", {16'd0, o_frame_cnt}, 2);
    cyc(0, 0, 0, 5'h00);
    chk("fcnt_after", {16'd0, o_frame_cnt}, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/brief_window_gen.md
BRIEF_WINDOW_GEN -- requirements
Module: brief_window_gen

Interface
REQ-001 Parameter IMG_WIDTH, default 1080, pixels per line; must match the line depth of the upstream line delays.
REQ-002 Parameter IMG_HEIGHT, default 720, lines per frame.
REQ-003 i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_en  input  1  pixel strobe; the same enable that drives the upstream line delays.
REQ-006 i_sof  input  1  start of frame; qualified by i_en; marks pixel (0,0).
REQ-007 i_row_taps  input  5  binary pixel column; bit k = pixel from k lines earlier (bit0 = current line, bit4 = oldest).
REQ-008 o_valid  output  1  o_window/o_col/o_row hold a complete interior 5x5 window.
REQ-009 o_window  output  25  window bits; index 5*dy+dx, dy=0 top (oldest) row, dx=0 leftmost (oldest) column.
REQ-010 o_col  output  11  window centre column.
REQ-011 o_row  output  11  window centre row.
REQ-012 o_eof  output  1  pulses with the last o_valid of a frame.

Function
REQ-013 Internal column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) shall give the position of the pixel accepted on each i_en.
REQ-014 On i_en: col increments; at IMG_WIDTH-1 it wraps to 0 and row increments; at (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0.
REQ-015 i_en with i_sof shall force the accepted pixel to (0,0), with counters continuing from there; i_sof without i_en is ignored.
REQ-016 On i_en, the 5x5 window register shall shift one column left and load i_row_taps into dx=4 (tap bit4 -> dy=0, bit0 -> dy=4).
REQ-017 With i_en low, window, counters and coordinate outputs shall hold, and o_valid/o_eof shall be 0.
REQ-018 o_valid shall be registered, asserted one cycle after an i_en whose pixel has col>=4 and row>=4, else 0.
REQ-019 When o_valid=1: o_col=col-2, o_row=row-2 of that pixel; o_window is the window after that shift.
REQ-020 o_eof=1 only with o_valid for pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-021 Border centres (within 2 of any edge) shall never produce o_valid; windows spanning a line wrap shall not be emitted.
REQ-022 Counter widths are 11 bits; IMG_WIDTH and IMG_HEIGHT shall be within 5..2047.

Reset
REQ-023 While i_rst=1: col, row and window are 0; o_valid, o_eof, o_window, o_col and o_row are 0.
REQ-024 Reset mid-frame shall discard the partial frame; the first i_en after reset is pixel (0,0) regardless of i_sof.
REQ-025 i_rst takes priority over i_en and i_sof in the same cycle.

Configuration
REQ-026 Macro BRIEF_FRAME_CNT_EN defined: add output o_frame_cnt (16 bits, reset 0), incremented one cycle after each o_eof and wrapping 0xFFFF->0.
REQ-027 BRIEF_FRAME_CNT_EN undefined: o_frame_cnt and its counter are absent, and all other behaviour is identical.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6)
REQ-028 All-ones taps for a full frame with continuous i_en -> exactly 8 o_valid pulses, each o_window=0x1FFFFFF; first at centre (2,2), last at (5,3) with o_eof=1.
REQ-029 Taps=5'b00001 only at pixel (4,4), else 0 -> valid at centre (2,2) has o_window=bit24 only; the next valid (centre (3,2)) has bit23 only.
REQ-030 Same frame as REQ-028 with i_en low every other cycle -> identical valid sequence; o_valid never high in the cycle after an i_en-low cycle.
REQ-031 i_sof with i_en at internal position (5,3) -> that pixel becomes (0,0); no o_valid until the new pixel (4,4).
REQ-032 i_rst pulse at pixel (6,5) -> all outputs 0 the next cycle; the following frame yields 8 valid windows starting at (2,2).
REQ-033 BRIEF_FRAME_CNT_EN defined, 3 full frames -> o_frame_cnt = 1, 2, 3, each changing one cycle after its o_eof.
